// File: rtl/lsu_pkg.sv
// lsu_pkg: definitions shared by the load/store unit and its load extender.
//   - lsu_state_t  : access sequencer states.
//   - F3_*         : Funct3 access size/sign encodings.
//   - f3_legal     : 1 when Funct3 names a supported access.
//   - byte_enable  : byte-lane enables for an access size and addr[1:0].
//   - store_data   : lane-replicated store data for an access size.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Half-word lanes ignore addr[0] and words ignore addr[1:0]; misaligned
    // accesses therefore fall onto the enclosing aligned half/word.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << addr_lo;
            F3_H, F3_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // The bus picks the lane with the byte enables, so the data is simply
    // replicated into every lane it could land in.
    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/half of a read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
//   mem_rdata [31:0] in  : raw word from the data bus.
//   addr_lo   [1:0]  in  : low address bits of the access.
//   funct3    [2:0]  in  : access size/sign (F3_* encodings).
//   ext_data  [31:0] out : extended load value.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[addr_lo];
    assign half_sel = addr_lo[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

    always_comb begin
        ext_data = mem_rdata;
        case (funct3)
            F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_data = {24'd0, byte_sel};
            F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_data = {16'd0, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage sequencer between the ALU address and a
// handshaked data-memory bus. Formats store data/byte enables, runs the
// request/response handshake with a timeout, stalls the pipeline while an
// access is outstanding and returns registered, extended load data.
//
// Optional feature macro: LSU_MISALIGN_EXC_EN
//   defined   : misaligned H/HU/W accesses skip the bus and pulse MisalignExc.
//   undefined : no MisalignExc port; low address bits are ignored.
//
// Ports:
//   clk, reset (async, active high)
//   MemRead, MemWrite, Funct3, ALUResult, WriteData : memory-stage inputs
//   Stall, ReadData, LoadValid, BusError            : pipeline outputs
//   MisalignExc (feature only)                      : misalignment pulse
//   MemReq, MemWe, MemAddr, MemWData, MemBE         : bus request
//   MemGnt, MemRValid, MemRData                     : bus response
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4      // 2**CNT_W must exceed MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        LoadValid,
    output logic        BusError,
`ifdef LSU_MISALIGN_EXC_EN
    output logic        MisalignExc,
`endif
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBE,
    input  logic        MemGnt,
    input  logic        MemRValid,
    input  logic [31:0] MemRData
);

    // Last counter value before the wait budget is exhausted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    lsu_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic [31:0]       addr_reg;
    logic [2:0]        f3_reg;
    logic [31:0]       wdata_reg;
    logic              store_reg;
    logic [31:0]       rdata_reg;
    logic [31:0]       ext_data;
    logic              capture;
    logic              rdata_load;
    logic              rdata_clear;
    logic              misalign_q;

`ifdef LSU_MISALIGN_EXC_EN
    logic misalign_reg, misalign_next;
    logic misaligned;

    assign misaligned = (((Funct3 == F3_H) || (Funct3 == F3_HU)) && ALUResult[0]) ||
                        ((Funct3 == F3_W) && (ALUResult[1:0] != 2'b00));
    assign misalign_q  = misalign_reg;
    assign MisalignExc = (state_reg == DONE) && misalign_reg;
`else
    assign misalign_q = 1'b0;
`endif

    load_extend u_load_extend (
        .mem_rdata (MemRData),
        .addr_lo   (addr_reg[1:0]),
        .funct3    (f3_reg),
        .ext_data  (ext_data)
    );

    // Address and data follow the captured fields at all times; the
    // qualifying signals (MemReq/MemWe/MemBE) are only active in REQ.
    assign MemAddr  = {addr_reg[31:2], 2'b00};
    assign MemWData = store_data(f3_reg, wdata_reg);
    assign ReadData = rdata_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        err_next    = err_reg;
`ifdef LSU_MISALIGN_EXC_EN
        misalign_next = misalign_reg;
`endif
        capture     = 1'b0;
        rdata_load  = 1'b0;
        rdata_clear = 1'b0;
        Stall       = 1'b0;
        MemReq      = 1'b0;
        MemWe       = 1'b0;
        MemBE       = 4'b0000;
        LoadValid   = 1'b0;
        BusError    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall    = 1'b1;
                    capture  = 1'b1;
                    err_next = 1'b0;
                    cnt_next = '0;
`ifdef LSU_MISALIGN_EXC_EN
                    misalign_next = 1'b0;
`endif
                    if (!f3_legal(Funct3)) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
`ifdef LSU_MISALIGN_EXC_EN
                    else if (misaligned) begin
                        misalign_next = 1'b1;
                        state_next    = DONE;
                    end
`endif
                    else begin
                        state_next = REQ;
                    end
                end
            end

            REQ: begin
                Stall  = 1'b1;
                MemReq = 1'b1;
                MemWe  = store_reg;
                MemBE  = byte_enable(f3_reg, addr_reg[1:0]);
                // The grant is checked before the timeout so a handshake on
                // the final allowed cycle still completes normally.
                if (MemGnt) begin
                    cnt_next   = '0;
                    state_next = store_reg ? DONE : RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next    = 1'b1;
                    rdata_clear = !store_reg;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            RESP: begin
                Stall = 1'b1;
                if (MemRValid) begin
                    rdata_load = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next    = 1'b1;
                    rdata_clear = 1'b1;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            DONE: begin
                // The instruction that owned this access is leaving the stage,
                // so MemRead/MemWrite are not looked at here.
                LoadValid  = !store_reg && !err_reg && !misalign_q;
                BusError   = err_reg;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_reg <= 1'b0;
`endif
            addr_reg  <= '0;
            f3_reg    <= '0;
            wdata_reg <= '0;
            store_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_reg <= misalign_next;
`endif
            if (capture) begin
                addr_reg  <= ALUResult;
                f3_reg    <= Funct3;
                wdata_reg <= WriteData;
                store_reg <= MemWrite;   // store wins when both are set
            end
            if (rdata_load) begin
                rdata_reg <= ext_data;
            end else if (rdata_clear) begin
                rdata_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit. Expected load
// results go into a scoreboard queue when an access is issued and are
// popped when LoadValid appears. Inputs change on the falling edge; outputs
// are sampled 1 ns later.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic        Stall;
    logic [31:0] ReadData;
    logic        LoadValid, BusError;
`ifdef LSU_MISALIGN_EXC_EN
    logic        MisalignExc;
`endif
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBE;
    logic        MemGnt, MemRValid;
    logic [31:0] MemRData;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    // Per-access observations.
    int          stall_n, req_n, lv_n, berr_n, ms_n;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    load_store_unit #(.MAX_WAIT(15), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Stall     (Stall),
        .ReadData  (ReadData),
        .LoadValid (LoadValid),
        .BusError  (BusError),
`ifdef LSU_MISALIGN_EXC_EN
        .MisalignExc (MisalignExc),
`endif
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemBE     (MemBE),
        .MemGnt    (MemGnt),
        .MemRValid (MemRValid),
        .MemRData  (MemRData)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one memory-stage instruction and plays the bus side.
    // gnt_wait / rv_wait: REQ / RESP cycles before the handshake (-1 = never).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
        int cyc;
        int resp_n;
        bit done;
        stall_n = 0; req_n = 0; lv_n = 0; berr_n = 0; ms_n = 0;
        cap_addr = '0; cap_wd = '0; cap_be = '0; cap_we = 1'b0;
        cyc = 0; resp_n = 0; done = 1'b0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
        MemGnt = 1'b0; MemRValid = 1'b0; MemRData = rdata;
        while (!done && cyc < 60) begin
            #1;
            if (Stall)     stall_n++;
            if (LoadValid) lv_n++;
            if (BusError)  berr_n++;
`ifdef LSU_MISALIGN_EXC_EN
            if (MisalignExc) ms_n++;
`endif
            if (cyc > 0 && !Stall) begin
                done = 1'b1;
                if (LoadValid) begin
                    if (exp_q.size() == 0)
                        check("sb_unexpected_load", {31'd0, LoadValid}, 32'd0);
                    else
                        check("sb_readdata", ReadData, exp_q.pop_front());
                end
            end else begin
                MemGnt = 1'b0;
                MemRValid = 1'b0;
                if (MemReq) begin
                    req_n++;
                    cap_addr = MemAddr; cap_wd = MemWData; cap_be = MemBE; cap_we = MemWe;
                    if (gnt_wait >= 0 && req_n == gnt_wait + 1) MemGnt = 1'b1;
                end else if (cyc > 0) begin
                    resp_n++;
                    if (rv_wait >= 0 && resp_n == rv_wait + 1) MemRValid = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("access_completed", 32'(done), 32'd1);
        MemRead = 1'b0; MemWrite = 1'b0; MemGnt = 1'b0; MemRValid = 1'b0;
    endtask

    initial begin
        int lv_cnt;
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; ALUResult = '0; WriteData = '0;
        MemGnt = 1'b0; MemRValid = 1'b0; MemRData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall",    {31'd0, Stall},     32'd0);
        check("rst_memreq",   {31'd0, MemReq},    32'd0);
        check("rst_readdata", ReadData,           32'd0);
        check("rst_loadvalid",{31'd0, LoadValid}, 32'd0);
        check("rst_buserror", {31'd0, BusError},  32'd0);
        check("rst_memaddr",  MemAddr,            32'd0);
        check("rst_membe",    {28'd0, MemBE},     32'd0);

        // LW 0x100, grant next cycle, data one cycle later.
        exp_q.push_back(32'hDEADBEEF);
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        $display("[TB] LW 0x100 stall=%0d rd=%h", stall_n, ReadData);
        check("lw_stall",   stall_n,          32'd3);
        check("lw_addr",    cap_addr,         32'h100);
        check("lw_be",      {28'd0, cap_be},  32'hF);
        check("lw_we",      {31'd0, cap_we},  32'd0);
        check("lw_lvpulse", lv_n,             32'd1);
        check("lw_berr",    berr_n,           32'd0);

        // LB / LBU at 0x103.
        exp_q.push_back(32'hFFFFFF80);
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF);
        $display("[TB] LB 0x103 be=%b rd=%h", cap_be, ReadData);
        check("lb_be", {28'd0, cap_be}, 32'b1000);
        check("lb_lv", lv_n, 32'd1);
        exp_q.push_back(32'h00000080);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF);
        $display("[TB] LBU 0x103 rd=%h", ReadData);
        check("lbu_lv", lv_n, 32'd1);

        // SH 0x202.
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, -1, 32'h0);
        $display("[TB] SH 0x202 addr=%h be=%b wd=%h we=%b", cap_addr, cap_be, cap_wd, cap_we);
        check("sh_addr",  cap_addr,         32'h200);
        check("sh_be",    {28'd0, cap_be},  32'b1100);
        check("sh_wd",    cap_wd,           32'hABCDABCD);
        check("sh_we",    {31'd0, cap_we},  32'd1);
        check("sh_stall", stall_n,          32'd2);
        check("sh_lv",    lv_n,             32'd0);
        check("sh_rdhold",ReadData,         32'h00000080);

        // SB 0x001 with a slow grant.
        access(1'b0, 1'b1, 3'b000, 32'h001, 32'h000000A5, 2, -1, 32'h0);
        $display("[TB] SB 0x001 be=%b wd=%h stall=%0d", cap_be, cap_wd, stall_n);
        check("sb_be",    {28'd0, cap_be}, 32'b0010);
        check("sb_wd",    cap_wd,          32'hA5A5A5A5);
        check("sb_req",   req_n,           32'd3);
        check("sb_stall", stall_n,         32'd4);

        // LHU 0x102.
        exp_q.push_back(32'h00008001);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80010000);
        $display("[TB] LHU 0x102 be=%b rd=%h", cap_be, ReadData);
        check("lhu_be",    {28'd0, cap_be}, 32'b1100);
        check("lhu_stall", stall_n,         32'd4);

        // Illegal Funct3: single stall cycle, no request, BusError.
        access(1'b0, 1'b1, 3'b111, 32'h40, 32'h1, 0, 0, 32'h0);
        $display("[TB] ILLEGAL f3 stall=%0d req=%0d berr=%0d", stall_n, req_n, berr_n);
        check("ill_stall",  stall_n,  32'd1);
        check("ill_req",    req_n,    32'd0);
        check("ill_berr",   berr_n,   32'd1);
        check("ill_rdhold", ReadData, 32'h00008001);

        // LH 0x101: misaligned half.
`ifdef LSU_MISALIGN_EXC_EN
        access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h12348765);
        $display("[TB] LH 0x101 misalign=%0d req=%0d", ms_n, req_n);
        check("lhm_exc",    ms_n,     32'd1);
        check("lhm_req",    req_n,    32'd0);
        check("lhm_berr",   berr_n,   32'd0);
        check("lhm_lv",     lv_n,     32'd0);
        check("lhm_rdhold", ReadData, 32'h00008001);
`else
        exp_q.push_back(32'hFFFF8765);
        access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h12348765);
        $display("[TB] LH 0x101 addr=%h be=%b rd=%h", cap_addr, cap_be, ReadData);
        check("lh_addr", cap_addr,         32'h100);
        check("lh_be",   {28'd0, cap_be},  32'b0011);
        check("lh_lv",   lv_n,             32'd1);
`endif

        // MemRead and MemWrite together: store.
        access(1'b1, 1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 0, 0, 32'h0);
        $display("[TB] RW both we=%b wd=%h", cap_we, cap_wd);
        check("rw_we",    {31'd0, cap_we}, 32'd1);
        check("rw_wd",    cap_wd,          32'hCAFEF00D);
        check("rw_lv",    lv_n,            32'd0);
        check("rw_stall", stall_n,         32'd2);

        // Handshakes on the last allowed cycle of REQ and RESP win.
        exp_q.push_back(32'h0BADCAFE);
        access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 14, 14, 32'h0BADCAFE);
        $display("[TB] LW edge-wait stall=%0d berr=%0d rd=%h", stall_n, berr_n, ReadData);
        check("edge_req",   req_n,   32'd15);
        check("edge_stall", stall_n, 32'd31);
        check("edge_berr",  berr_n,  32'd0);
        check("edge_lv",    lv_n,    32'd1);

        // LW with no grant: timeout.
        access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, -1, -1, 32'h0);
        $display("[TB] LW timeout req=%0d berr=%0d rd=%h", req_n, berr_n, ReadData);
        check("to_req",   req_n,    32'd15);
        check("to_stall", stall_n,  32'd16);
        check("to_berr",  berr_n,   32'd1);
        check("to_lv",    lv_n,     32'd0);
        check("to_rd",    ReadData, 32'd0);

        // Load a nonzero value, then reset in the middle of a load's RESP.
        exp_q.push_back(32'h55AA1234);
        access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h55AA1234);
        $display("[TB] LW 0x300 rd=%h", ReadData);
        @(negedge clk);
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h400;
        @(negedge clk);
        #1;
        check("rr_req", {31'd0, MemReq}, 32'd1);
        MemGnt = 1'b1;
        @(negedge clk);
        MemGnt = 1'b0;
        #1;
        check("rr_resp_stall", {31'd0, Stall}, 32'd1);
        reset = 1'b1;
        MemRead = 1'b0;
        #1;
        check("rr_rst_memreq", {31'd0, MemReq}, 32'd0);
        check("rr_rst_rd",     ReadData,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        MemRValid = 1'b1; MemGnt = 1'b1; MemRData = 32'hFFFFFFFF;
        lv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (LoadValid) lv_cnt++;
            @(negedge clk);
            MemRValid = 1'b0; MemGnt = 1'b0;
        end
        #1;
        $display("[TB] reset-in-RESP lv=%0d rd=%h req=%b", lv_cnt, ReadData, MemReq);
        check("rr_lv",     lv_cnt,          32'd0);
        check("rr_rd",     ReadData,        32'd0);
        check("rr_memreq", {31'd0, MemReq}, 32'd0);
        check("rr_stall",  {31'd0, Stall},  32'd0);

        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block between the ALU address output and a handshaked data-memory bus.
- Formats store data and byte enables. Sequences the bus request/response and stalls the pipeline while an access is outstanding.
- Returns a sign- or zero-extended, registered ReadData to the writeback result multiplexer.

Parameters:
- MAX_WAIT, 15: cycles allowed in REQ or RESP before the access is aborted with BusError.
- CNT_W, 4: wait-counter width; must satisfy 2**CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  current memory-stage instruction is a load.
- MemWrite  in  1  current memory-stage instruction is a store.
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  in  32  effective byte address.
- WriteData  in  32  store data (rs2).
- Stall  out  1  freezes the pipeline stages up to and including memory.
- ReadData  out  32  extended load data to the result multiplexer; registered.
- LoadValid  out  1  one-cycle pulse; ReadData holds a new load value.
- BusError  out  1  one-cycle pulse; access timed out or Funct3 was illegal.
- MemReq  out  1  bus request.
- MemWe  out  1  1 = write, 0 = read.
- MemAddr  out  32  word-aligned address, ALUResult[31:2] followed by 2'b00.
- MemWData  out  32  lane-replicated store data.
- MemBE  out  4  byte-lane enables.
- MemGnt  in  1  bus accepted the request this cycle.
- MemRValid  in  1  read data valid.
- MemRData  in  32  read data.

Behaviour:
- States: IDLE, REQ, RESP, DONE.
- Reset is asynchronous and active-high. State goes to IDLE; all outputs, the counter and the captured fields go to 0. Reset mid-access abandons the access; late MemGnt/MemRValid are ignored.
- IDLE: if MemRead or MemWrite, Stall=1 combinationally. The next edge captures address, Funct3, WriteData and direction and moves to REQ. If both MemRead and MemWrite are high, the access is a store.
- REQ: MemReq=1 and Stall=1; MemAddr/MemWData/MemBE/MemWe are driven from the captured fields. On MemGnt, a store goes to DONE and a load goes to RESP.
- RESP: Stall=1. On MemRValid, the extended MemRData is registered into ReadData and the state moves to DONE.
- DONE: Stall=0 and MemReq=0. LoadValid=1 for loads, or BusError=1. MemRead/MemWrite are ignored because it is the same instruction leaving. The next state is IDLE.
- Minimum stall: 2 cycles for a store, 3 cycles for a load.
- Counter:
  - Clears on entry to REQ and RESP; increments each cycle spent there.
  - When it reaches MAX_WAIT without the awaited MemGnt/MemRValid, go to DONE with BusError=1.
  - A timed-out load sets ReadData=0.
  - A handshake arriving on the same cycle the counter hits MAX_WAIT wins (no error).
- MemRValid outside RESP is ignored.
- Byte enables:
  - B: 0001 shifted left by addr[1:0].
  - H: 0011 shifted left by {addr[1],0}.
  - W: 1111.
- Store data: byte replicated 4x, halfword 2x, word as-is.
- Load extraction:
  - Byte: byte lane addr[1:0].
  - Half: half lane addr[1].
  - Sign-extended for B/H, zero-extended for BU/HU.
- Illegal Funct3 (011, 110, 111): no bus request. IDLE goes directly to DONE with BusError=1; Stall=1 for that single cycle.
- ReadData holds its value until the next completed load or timeout.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: a misaligned H/HU/W access (H with addr[0]=1, W with addr[1:0]≠0) issues no bus request. It goes IDLE→DONE with an extra output MisalignExc (1 bit, one-cycle pulse in DONE); ReadData is unchanged.
- Undefined: MisalignExc port is absent. The offending low address bits are ignored: half uses addr[1], word uses the aligned word, and the access proceeds normally.

Decomposition:
- Shared package lsu_pkg contains:
  - the state enum;
  - Funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a byte-enable function of size and addr[1:0].
- One combinational sub-module, load_extend: takes MemRData, addr[1:0] and Funct3, and produces the 32-bit extended value.

Test Plan:
- LW at 0x100; MemGnt next cycle; MemRValid with 0xDEADBEEF one cycle later → Stall high 3 cycles, ReadData=0xDEADBEEF, LoadValid pulse in DONE.
- LB at 0x103 with MemRData=0x80FF_FFFF → MemBE=1000, ReadData=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x202 with WriteData=0x1234_ABCD → MemAddr=0x200, MemBE=1100, MemWData=0xABCD_ABCD, MemWe=1.
- LW with MemGnt never asserted, MAX_WAIT=15 → BusError pulse after 15 REQ cycles, ReadData=0, Stall released.
- Reset asserted while in RESP, then MemRValid arrives → state IDLE, MemReq=0, ReadData=0, no LoadValid.
- LH at 0x101:
  - with LSU_MISALIGN_EXC_EN: MisalignExc pulse, MemReq never asserted;
  - without it: request at 0x100 with MemBE=0011.
